// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator job scheduler: job word, error/status codes, FSM states.
package cfg_types_pkg;

    typedef enum logic [1:0] {
        ER_OKAY        = 2'd0,
        ER_MAXCNT_ZERO = 2'd1,
        ER_MAXCNT_ODD  = 2'd2,
        ER_INCR        = 2'd3
    } acc_error_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RUNNING = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [7:0] max_cnt;
        logic [7:0] incr;
    } acc_job_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        DISPATCH = 3'd2,
        RUN      = 3'd3,
        COMPLETE = 3'd4,
        HALT     = 3'd5
    } sched_state_t;

    // The accelerator only accepts a non-zero, even word count.
    function automatic logic job_is_valid(input acc_job_t job);
        return (job.max_cnt != '0) && !job.max_cnt[0];
    endfunction

endpackage

// File: rtl/acc_job_fifo.sv
// Synchronous job FIFO; head entry is read combinationally, flush empties it in one cycle.
module acc_job_fifo
    import cfg_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  acc_job_t                 i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output acc_job_t                 o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    acc_job_t         r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // DEPTH is a power of two, so the level MSB alone marks full.
    assign o_full    = r_level[AW];
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/acc_job_sched.sv
// Job scheduler in front of the accelerator sequencer: queue, validate, dispatch, count, interrupt.
// Optional RUN watchdog with sticky HALT state and timeout output: define ACC_SCHED_TIMEOUT_EN.
module acc_job_sched
    import cfg_types_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [7:0]                    push_max_cnt,
    input  logic [7:0]                    push_incr,
    input  logic                          flush,
    output logic                          acc_start,
    output logic [7:0]                    acc_max_cnt,
    output logic [7:0]                    acc_incr,
    input  logic                          acc_done,
    input  acc_error_t                    acc_error,
    output acc_state_t                    sched_state,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level,
    output logic [CNT_WIDTH-1:0]          jobs_done,
    output logic [CNT_WIDTH-1:0]          jobs_rej,
    output logic                          irq,
    input  logic                          irq_clr
`ifdef ACC_SCHED_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("acc_job_sched: QUEUE_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    sched_state_t           r_state;
    sched_state_t           w_state_nx;
    acc_job_t               r_job;
    acc_job_t               w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_rej;
    logic                   w_cmp;
    logic                   w_irq_set;
    logic [CNT_WIDTH-1:0]   r_jobs_done;
    logic [CNT_WIDTH-1:0]   r_jobs_rej;
    logic                   r_irq;

    assign push_ready = !w_full && !flush;
    assign w_push     = push_valid && push_ready;
    assign w_pop      = (r_state == IDLE) && !w_empty && !flush;

    acc_job_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ('{max_cnt: push_max_cnt, incr: push_incr}),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_data  (w_head),
        .o_level (queue_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WDW-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_wdog <= '0;
        else if (r_state != RUN)   r_wdog <= '0;
        else                       r_wdog <= r_wdog + 1'b1;
    end

    assign timeout = (r_state == HALT);
`endif

    always_comb begin
        w_state_nx = r_state;
        w_rej      = 1'b0;
        w_cmp      = 1'b0;
        case (r_state)
            IDLE:     if (w_pop) w_state_nx = LOAD;
            LOAD: begin
                if (job_is_valid(r_job)) begin
                    w_state_nx = DISPATCH;
                end else begin
                    w_rej      = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            DISPATCH: w_state_nx = RUN;
            RUN: begin
                // An error report outranks a coincident done.
                if (acc_error != ER_OKAY) begin
                    w_rej      = 1'b1;
                    w_state_nx = IDLE;
                end else if (acc_done) begin
                    w_state_nx = COMPLETE;
                end
`ifdef ACC_SCHED_TIMEOUT_EN
                else if (r_wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
                    w_rej      = 1'b1;
                    w_state_nx = HALT;
                end
`endif
            end
            COMPLETE: begin
                w_cmp      = 1'b1;
                w_state_nx = IDLE;
            end
`ifdef ACC_SCHED_TIMEOUT_EN
            HALT:     if (flush) w_state_nx = IDLE;
`endif
            default:  w_state_nx = IDLE;
        endcase
    end

    assign w_irq_set = w_rej || (w_cmp && w_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_job       <= '0;
            r_jobs_done <= '0;
            r_jobs_rej  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_pop) r_job <= w_head;
            if (w_cmp && !(&r_jobs_done)) r_jobs_done <= r_jobs_done + 1'b1;
            if (w_rej && !(&r_jobs_rej))  r_jobs_rej  <= r_jobs_rej + 1'b1;
            if (w_irq_set)    r_irq <= 1'b1;
            else if (irq_clr) r_irq <= 1'b0;
        end
    end

    assign acc_start   = (r_state == DISPATCH);
    assign acc_max_cnt = r_job.max_cnt;
    assign acc_incr    = r_job.incr;
    assign sched_state = (r_state inside {LOAD, DISPATCH, RUN, COMPLETE}) ? ST_RUNNING : ST_IDLE;
    assign jobs_done   = r_jobs_done;
    assign jobs_rej    = r_jobs_rej;
    assign irq         = r_irq;

endmodule

// File: tb/tb_acc_job_sched.sv
// Scoreboard bench for acc_job_sched: dispatch order/timing checked by a monitor, accelerator modelled.
// Build with ACC_SCHED_TIMEOUT_EN to add the watchdog/HALT scenario.
module tb_acc_job_sched;
    import cfg_types_pkg::*;

    localparam int TB_CW = 3;
    localparam int LAT   = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [7:0]  push_max_cnt;
    logic [7:0]  push_incr;
    logic        flush;
    logic        acc_start;
    logic [7:0]  acc_max_cnt;
    logic [7:0]  acc_incr;
    logic        acc_done;
    acc_error_t  acc_error;
    acc_state_t  sched_state;
    logic [2:0]  queue_level;
    logic [TB_CW-1:0] jobs_done;
    logic [TB_CW-1:0] jobs_rej;
    logic        irq;
    logic        irq_clr;
`ifdef ACC_SCHED_TIMEOUT_EN
    logic        timeout;
`endif

    acc_job_sched #(
        .QUEUE_DEPTH    (4),
        .CNT_WIDTH      (TB_CW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_max_cnt (push_max_cnt),
        .push_incr    (push_incr),
        .flush        (flush),
        .acc_start    (acc_start),
        .acc_max_cnt  (acc_max_cnt),
        .acc_incr     (acc_incr),
        .acc_done     (acc_done),
        .acc_error    (acc_error),
        .sched_state  (sched_state),
        .queue_level  (queue_level),
        .jobs_done    (jobs_done),
        .jobs_rej     (jobs_rej),
        .irq          (irq),
        .irq_clr      (irq_clr)
`ifdef ACC_SCHED_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int satv(input int n);
        return (n > (1 << TB_CW) - 1) ? (1 << TB_CW) - 1 : n;
    endfunction

    // mode 0: no timing check; 1: start at absolute cycle; 2: start 4 cycles after the last done
    typedef struct {
        logic [7:0] mc;
        logic [7:0] inc;
        int         mode;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    task automatic sb_add(input logic [7:0] mc, input logic [7:0] inc, input int mode, input int c);
        exp_t e;
        e.mc = mc; e.inc = inc; e.mode = mode; e.cyc = c;
        sb.push_back(e);
    endtask

    // Accelerator model and dispatch monitor
    logic       busy = 1'b0;
    logic       model_en = 1'b1;
    int         lat_cnt = 0;
    int         last_done = 0;
    logic [7:0] cap_mc = '0;
    logic [7:0] cap_inc = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy     = 1'b0;
            acc_done = 1'b0;
        end else begin
            acc_done = 1'b0;
            if (acc_start) begin
                exp_t e;
                check("start_while_busy", {31'b0, busy}, 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: actual max_cnt=%0d required no dispatch (cycle %0d)", acc_max_cnt, cyc);
                end else begin
                    e = sb.pop_front();
                    check("start_max_cnt", acc_max_cnt, e.mc);
                    check("start_incr", acc_incr, e.inc);
                    if (e.mode == 1) check("start_cycle", cyc, e.cyc);
                    if (e.mode == 2) check("start_gap_after_done", cyc, last_done + 4);
                end
                if (model_en) begin
                    busy    = 1'b1;
                    lat_cnt = LAT;
                    cap_mc  = acc_max_cnt;
                    cap_inc = acc_incr;
                end
            end else if (busy) begin
                check("hold_max_cnt", acc_max_cnt, cap_mc);
                check("hold_incr", acc_incr, cap_inc);
                lat_cnt--;
                if (lat_cnt == 0) begin
                    acc_done  = 1'b1;
                    busy      = 1'b0;
                    last_done = cyc;
                end
            end
        end
    end

    task automatic wait_idle(input string name, input logic chk_irq_early);
        int   n = 0;
        logic early = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (irq && (sb.size() != 0 || busy || queue_level != 0)) early = 1'b1;
        end while (n < 400 && !(sb.size() == 0 && !busy && sched_state == ST_IDLE && queue_level == 0));
        check({name, "_drain_in_budget"}, {31'b0, n < 400}, 1);
        if (chk_irq_early) check({name, "_irq_early"}, {31'b0, early}, 0);
        @(negedge clk);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", {31'b0, irq}, 0);
    endtask

    task automatic push_seq(input logic [7:0] mc, input logic [7:0] inc);
        push_valid   = 1'b1;
        push_max_cnt = mc;
        push_incr    = inc;
        #1;
        check("push_ready", {31'b0, push_ready}, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        int exp_done;
        int exp_rej;
        int n;
        rst_n = 1'b0; push_valid = 1'b0; push_max_cnt = '0; push_incr = '0;
        flush = 1'b0; irq_clr = 1'b0; acc_error = ER_OKAY;
        exp_done = 0; exp_rej = 0;
        repeat (3) @(negedge clk);
        check("rst_push_ready", {31'b0, push_ready}, 1);
        check("rst_acc_start", {31'b0, acc_start}, 0);
        check("rst_acc_max_cnt", acc_max_cnt, 0);
        check("rst_acc_incr", acc_incr, 0);
        check("rst_state", sched_state, ST_IDLE);
        check("rst_level", queue_level, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_jobs_rej", jobs_rej, 0);
        check("rst_irq", {31'b0, irq}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single job, start three cycles after push
        c = cyc;
        sb_add(8'd8, 8'd1, 1, c + 3);
        push_seq(8'd8, 8'd1);
        push_valid = 1'b0;
        wait_idle("t1", 1'b1);
        exp_done = 1;
        check("t1_jobs_done", jobs_done, satv(exp_done));
        check("t1_jobs_rej", jobs_rej, exp_rej);
        check("t1_irq", {31'b0, irq}, 1);
        check("t1_max_cnt_retained", acc_max_cnt, 8);
        clear_irq();

        // five back-to-back pushes; queue fills to 4 while the first job runs
        c = cyc;
        sb_add(8'd4, 8'd1, 1, c + 3);
        sb_add(8'd6, 8'd2, 2, 0);
        sb_add(8'd8, 8'd3, 2, 0);
        sb_add(8'd10, 8'd4, 2, 0);
        sb_add(8'd12, 8'd5, 2, 0);
        push_seq(8'd4, 8'd1);
        push_seq(8'd6, 8'd2);
        push_seq(8'd8, 8'd3);
        push_seq(8'd10, 8'd4);
        push_seq(8'd12, 8'd5);
        push_max_cnt = 8'd2; push_incr = 8'd2;
        #1;
        check("t2_full_level", queue_level, 4);
        check("t2_full_push_ready", {31'b0, push_ready}, 0);
        @(negedge clk);
        push_valid = 1'b0;
        check("t2_full_push_dropped", queue_level, 4);
        wait_idle("t2", 1'b1);
        exp_done = 6;
        check("t2_jobs_done", jobs_done, satv(exp_done));
        check("t2_irq", {31'b0, irq}, 1);
        clear_irq();

        // accelerator error during RUN rejects the job; the later done pulse is ignored
        c = cyc;
        acc_error = ER_INCR;
        sb_add(8'd4, 8'd1, 1, c + 3);
        push_seq(8'd4, 8'd1);
        push_valid = 1'b0;
        wait_idle("terr", 1'b0);
        acc_error = ER_OKAY;
        exp_rej = 1;
        check("terr_jobs_rej", jobs_rej, satv(exp_rej));
        check("terr_jobs_done", jobs_done, satv(exp_done));
        check("terr_irq", {31'b0, irq}, 1);
        clear_irq();

        // odd and zero max_cnt rejected in LOAD, valid job dispatched after them
        c = cyc;
        sb_add(8'd4, 8'd1, 1, c + 7);
        push_seq(8'd7, 8'd1);
        push_seq(8'd0, 8'd1);
        push_seq(8'd4, 8'd1);
        push_valid = 1'b0;
        wait_idle("t3", 1'b0);
        exp_rej = 3; exp_done = 7;
        check("t3_jobs_rej", jobs_rej, satv(exp_rej));
        check("t3_jobs_done", jobs_done, satv(exp_done));
        check("t3_irq", {31'b0, irq}, 1);
        clear_irq();

        // flush with two queued and a push pending while a job runs
        c = cyc;
        sb_add(8'd20, 8'd1, 1, c + 3);
        push_seq(8'd20, 8'd1);
        push_seq(8'd2, 8'd1);
        push_seq(8'd4, 8'd2);
        push_valid = 1'b0;
        @(negedge clk);
        check("t4_running", sched_state, ST_RUNNING);
        check("t4_level_before", queue_level, 2);
        flush = 1'b1; push_valid = 1'b1; push_max_cnt = 8'd6; push_incr = 8'd6;
        #1;
        check("t4_push_ready_flush", {31'b0, push_ready}, 0);
        @(negedge clk);
        flush = 1'b0; push_valid = 1'b0;
        check("t4_level_after", queue_level, 0);
        check("t4_still_running", sched_state, ST_RUNNING);
        wait_idle("t4", 1'b0);
        exp_done = 8;
        check("t4_jobs_done_sat", jobs_done, satv(exp_done));
        check("t4_irq", {31'b0, irq}, 1);
        clear_irq();

        // irq set beats a same-cycle irq_clr in COMPLETE
        c = cyc;
        sb_add(8'd2, 8'd1, 1, c + 3);
        push_seq(8'd2, 8'd1);
        push_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!acc_done && n < 50);
        check("t5_done_seen", {31'b0, n < 50}, 1);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        check("t5_irq_set_priority", {31'b0, irq}, 1);
        @(negedge clk);
        irq_clr = 1'b0;
        check("t5_irq_clr_later", {31'b0, irq}, 0);
        exp_done = 9;
        check("t5_jobs_done_sat", jobs_done, satv(exp_done));

        // reset in the middle of a running job
        c = cyc;
        sb_add(8'd10, 8'd3, 1, c + 3);
        push_seq(8'd10, 8'd3);
        push_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_running", sched_state, ST_RUNNING);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", sched_state, ST_IDLE);
        check("t6_rst_max_cnt", acc_max_cnt, 0);
        check("t6_rst_jobs_done", jobs_done, 0);
        check("t6_rst_jobs_rej", jobs_rej, 0);
        check("t6_rst_irq", {31'b0, irq}, 0);
        check("t6_rst_push_ready", {31'b0, push_ready}, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ACC_SCHED_TIMEOUT_EN
        // watchdog: no done for 16 RUN cycles enters HALT until flush
        model_en = 1'b0;
        c = cyc;
        sb_add(8'd4, 8'd1, 1, c + 3);
        push_seq(8'd4, 8'd1);
        push_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("tw_not_yet", {31'b0, timeout}, 0);
        check("tw_running", sched_state, ST_RUNNING);
        @(negedge clk);
        check("tw_timeout", {31'b0, timeout}, 1);
        check("tw_state", sched_state, ST_IDLE);
        check("tw_jobs_rej", jobs_rej, 1);
        check("tw_irq", {31'b0, irq}, 1);
        push_seq(8'd2, 8'd2);
        push_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("tw_halt_no_dispatch", queue_level, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("tw_flush_exit", {31'b0, timeout}, 0);
        check("tw_flush_level", queue_level, 0);
        repeat (5) @(negedge clk);
        model_en = 1'b1;
`endif

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
